sw_dispatch_arbiter: RTL and testbench

Request dispatcher and resource arbiter for the switch-instance pool that feeds the rx_module response path. It accepts one tagged request per cycle on a valid/ready interface, grants it to a free switch instance in round-robin order, and drives the one-hot `sel_en`/`op_id` pair the response path latches. It tracks every outstanding instance until its `ack`, and reclaims instances that never answer via a per-instance timeout.

---
 rtl/sw_dispatch_arbiter.sv | 134 +++++++++++++
 tb/tb_sw_dispatch_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_dispatch_arbiter.sv
// Round-robin dispatcher for a pool of switch instances: grants one request per
// cycle to a free instance, tracks it until ack, and reclaims it on timeout.
module sw_dispatch_arbiter #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_op_id,
  input  logic [W_WIDTH-1:0]     req_addr,
  input  logic [NUM_SW_INST-1:0] sw_busy,
  input  logic [NUM_SW_INST-1:0] ack,
  output logic [NUM_SW_INST-1:0] sel_en,
  output logic [7:0]             op_id_out,
  output logic [W_WIDTH-1:0]     addr_out,
  output logic [NUM_SW_INST-1:0] pending,
  output logic                   idle,
  output logic [NUM_SW_INST-1:0] timeout_mask,
  output logic                   spurious_ack
);

  localparam int              IW       = $clog2(NUM_SW_INST);
  localparam logic [15:0]     CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NUM_SW_INST - 1);

  logic [NUM_SW_INST-1:0] pending_q;
  logic [NUM_SW_INST-1:0] timeout_q;
  logic [NUM_SW_INST-1:0] sel_en_q;
  logic [NUM_SW_INST-1:0] free;
  logic [NUM_SW_INST-1:0] grant_oh;
  logic [IW-1:0]          rr_ptr_q;
  logic [IW-1:0]          grant_idx;
  logic                   grant_found;
  logic                   accept;
  logic [7:0]             op_id_q;
  logic [W_WIDTH-1:0]     addr_q;
  logic                   spurious_q;

  assign free      = ~pending_q & ~sw_busy;
  assign req_ready = en & (|free);
  assign accept    = req_valid & req_ready;

  // Walk the pool starting one past the last grant; first free index wins.
  always_comb begin
    logic [IW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = rr_ptr_q;
    for (int k = 0; k < NUM_SW_INST; k++) begin
      cand = (cand == IDX_LAST) ? '0 : cand + IW'(1);
      if (!grant_found && free[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_inst
    logic        pend_q;
    logic        pend_d;
    logic        to_q;
    logic        to_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign grant_oh[gi] = accept & grant_found & (grant_idx == IW'(gi));

    // Ack outranks the reclaim check, which in turn precedes the increment.
    always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      to_d   = 1'b0;
      if (grant_oh[gi]) begin
        pend_d = 1'b1;
        cnt_d  = '0;
      end else if (pend_q) begin
        if (ack[gi]) begin
          pend_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          pend_d = 1'b0;
          to_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q <= 1'b0;
        to_q   <= 1'b0;
        cnt_q  <= '0;
      end else begin
        pend_q <= pend_d;
        to_q   <= to_d;
        cnt_q  <= cnt_d;
      end
    end

    assign pending_q[gi] = pend_q;
    assign timeout_q[gi] = to_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= IDX_LAST;
      sel_en_q   <= '0;
      op_id_q    <= '0;
      addr_q     <= '0;
      spurious_q <= 1'b0;
    end else begin
      sel_en_q   <= grant_oh;
      spurious_q <= |(ack & ~pending_q);
      if (accept) begin
        rr_ptr_q <= grant_idx;
        op_id_q  <= req_op_id;
        addr_q   <= req_addr;
      end
    end
  end

  assign sel_en       = sel_en_q;
  assign op_id_out    = op_id_q;
  assign addr_out     = addr_q;
  assign pending      = pending_q;
  assign idle         = ~|pending_q;
  assign timeout_mask = timeout_q;
  assign spurious_ack = spurious_q;

endmodule

// File: tb/tb_sw_dispatch_arbiter.sv
// Bench for sw_dispatch_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a deadline-based reference model.
module tb_sw_dispatch_arbiter;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_op_id;
  logic [W-1:0] req_addr;
  logic [N-1:0] sw_busy;
  logic [N-1:0] ack;
  logic [N-1:0] sel_en;
  logic [7:0]   op_id_out;
  logic [W-1:0] addr_out;
  logic [N-1:0] pending;
  logic         idle;
  logic [N-1:0] timeout_mask;
  logic         spurious_ack;

  sw_dispatch_arbiter #(.NUM_SW_INST(N), .W_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_id(req_op_id), .req_addr(req_addr), .sw_busy(sw_busy), .ack(ack),
    .sel_en(sel_en), .op_id_out(op_id_out), .addr_out(addr_out), .pending(pending),
    .idle(idle), .timeout_mask(timeout_mask), .spurious_ack(spurious_ack)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each pending instance carries an absolute deadline cycle.
  bit           m_pend[N];
  int           m_deadline[N];
  int           m_last;
  logic [N-1:0] m_sel;
  logic [N-1:0] m_to;
  logic [7:0]   m_op;
  logic [W-1:0] m_addr;
  bit           m_spur;
  int           cyc = 0;

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit m_ready();
    bit any_free;
    any_free = 1'b0;
    for (int i = 0; i < N; i++) if (!m_pend[i] && !sw_busy[i]) any_free = 1'b1;
    return en && any_free;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i]     = 1'b0;
      m_deadline[i] = 0;
    end
    m_last = N - 1;
    m_sel  = '0;
    m_to   = '0;
    m_op   = '0;
    m_addr = '0;
    m_spur = 1'b0;
  endtask

  task automatic model_edge();
    int g;
    int c;
    g = -1;
    if (req_valid && m_ready()) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (g < 0 && !m_pend[c] && !sw_busy[c]) g = c;
      end
    end
    m_to   = '0;
    m_spur = 1'b0;
    for (int i = 0; i < N; i++) if (ack[i] && !m_pend[i]) m_spur = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i]) begin
        if (ack[i]) begin
          m_pend[i] = 1'b0;
        end else if (cyc == m_deadline[i] - 1) begin
          m_pend[i] = 1'b0;
          m_to[i]   = 1'b1;
        end
      end
    end
    m_sel = '0;
    if (g >= 0) begin
      m_pend[g]     = 1'b1;
      m_deadline[g] = cyc + 1 + TO;
      m_last        = g;
      m_sel[g]      = 1'b1;
      m_op          = req_op_id;
      m_addr        = req_addr;
      $display("grant idx=%0d op=0x%02h addr=0x%02h cycle=%0d", g, req_op_id, req_addr, cyc);
    end
    cyc++;
  endtask

  task automatic step();
    #1;
    check_eq("req_ready", req_ready, m_ready());
    @(posedge clk);
    model_edge();
    #1;
    check_eq("sel_en", sel_en, m_sel);
    check_eq("op_id_out", op_id_out, m_op);
    check_eq("addr_out", addr_out, m_addr);
    check_eq("pending", pending, m_pend_vec());
    check_eq("idle", idle, m_pend_vec() == '0);
    check_eq("timeout_mask", timeout_mask, m_to);
    check_eq("spurious_ack", spurious_ack, m_spur);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst_async_pending", pending, 0);
    check_eq("rst_async_sel", sel_en, 0);
    check_eq("rst_async_idle", idle, 1);
    repeat (ncyc) @(posedge clk);
    #1;
    check_eq("rst_sel", sel_en, 0);
    check_eq("rst_op", op_id_out, 0);
    check_eq("rst_addr", addr_out, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_timeout", timeout_mask, 0);
    check_eq("rst_spurious", spurious_ack, 0);
    check_eq("rst_idle", idle, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (!idle && guard < 64) begin
      step();
      guard++;
    end
    check_eq("drain_idle", idle, 1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; req_valid = 1'b0; req_op_id = '0; req_addr = '0;
    sw_busy = '0; ack = '0;
    do_reset(3);

    // Pool fill: five grants in index order, sixth request stalls.
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_op_id = 8'(8'h10 + k);
      req_addr  = W'($urandom);
      step();
      check_eq("fill_sel", sel_en, 32'(1) << k);
      check_eq("fill_op", op_id_out, 32'h10 + k);
    end
    req_op_id = 8'h15;
    #1 check_eq("fill_full_ready", req_ready, 0);
    step();
    check_eq("fill_held_nosel", sel_en, 0);

    // Round robin after ack[3] then ack[0].
    ack = 5'b01000;
    step();
    ack = '0;
    check_eq("rr_pending_after_ack3", pending, 5'b10111);
    ack = 5'b00001;
    step();
    ack = '0;
    check_eq("rr_grant3", sel_en, 5'b01000);
    check_eq("rr_op15", op_id_out, 8'h15);
    req_op_id = 8'h16;
    step();
    check_eq("rr_grant0", sel_en, 5'b00001);
    req_valid = 1'b0;
    drain();

    // Spurious acks: single and double.
    ack = 5'b00100;
    step();
    ack = '0;
    check_eq("spur_pulse", spurious_ack, 1);
    check_eq("spur_pending", pending, 0);
    step();
    check_eq("spur_clear", spurious_ack, 0);
    ack = 5'b10100;
    step();
    ack = '0;
    check_eq("spur_double", spurious_ack, 1);
    step();

    // Mid-stream reset with three pending instances.
    req_valid = 1'b1;
    repeat (3) step();
    req_valid = 1'b0;
    check_eq("pre_rst_pending_cnt", $countones(pending), 3);
    do_reset(3);
    #1 check_eq("post_rst_ready", req_ready, 1);

    // Timeout with no ack.
    req_valid = 1'b1;
    req_op_id = 8'h20;
    step();
    req_valid = 1'b0;
    check_eq("post_rst_grant0", sel_en, 5'b00001);
    for (int t = 1; t < TO; t++) begin
      step();
      check_eq("to_quiet", timeout_mask, 0);
    end
    step();
    check_eq("to_pulse", timeout_mask, 5'b00001);
    check_eq("to_pending", pending, 0);
    step();
    check_eq("to_single", timeout_mask, 0);

    // Ack in the last allowed cycle suppresses the timeout.
    sw_busy = 5'b11110;
    req_valid = 1'b1;
    step();
    sw_busy = '0;
    req_valid = 1'b0;
    check_eq("busy_grant0", sel_en, 5'b00001);
    for (int t = 1; t < TO; t++) step();
    ack = 5'b00001;
    step();
    ack = '0;
    check_eq("to_acked_nopulse", timeout_mask, 0);
    check_eq("to_acked_pending", pending, 0);
    step();
    check_eq("to_acked_later", timeout_mask, 0);

    // Ack and request in the same cycle: grant only on the following cycle.
    sw_busy = 5'b11101;
    req_valid = 1'b1;
    req_op_id = 8'h30;
    step();
    check_eq("sim_first_grant1", sel_en, 5'b00010);
    req_op_id = 8'h31;
    ack = 5'b00010;
    #1 check_eq("sim_ready_low", req_ready, 0);
    step();
    ack = '0;
    check_eq("sim_nosel", sel_en, 0);
    check_eq("sim_pending_clear", pending, 0);
    step();
    check_eq("sim_next_grant1", sel_en, 5'b00010);
    req_valid = 1'b0;
    sw_busy = '0;
    drain();

    // Busy mask redirects the first post-reset grant; en=0 blocks accepts.
    do_reset(2);
    sw_busy = 5'b00001;
    req_valid = 1'b1;
    step();
    check_eq("busy_grant1", sel_en, 5'b00010);
    sw_busy = '0;
    step();
    en = 1'b0;
    #1 check_eq("en0_ready", req_ready, 0);
    ack = 5'b00010;
    step();
    ack = '0;
    check_eq("en0_ack_clears", pending, 5'b00100);
    check_eq("en0_nosel", sel_en, 0);
    step();
    en = 1'b1;
    req_valid = 1'b0;
    drain();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom % 8) != 0;
      req_valid = ($urandom % 3) != 0;
      req_op_id = 8'($urandom);
      req_addr  = W'($urandom);
      sw_busy   = (($urandom % 4) == 0) ? N'($urandom) : '0;
      ack       = m_pend_vec() & N'($urandom) & N'($urandom);
      if (($urandom % 16) == 0) ack = ack | N'($urandom);
      if (($urandom % 500) == 0) begin
        do_reset(1 + int'($urandom % 3));
      end
      step();
    end
    en = 1'b1; req_valid = 1'b0; ack = '0; sw_busy = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
